// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: mode encodings, angle units, arctangent table,
// reciprocal gain and the rotator FSM state encoding.
package cordic_pkg;

  localparam logic [1:0] MODE_LINEAR     = 2'b00;
  localparam logic [1:0] MODE_CIRCULAR   = 2'b10;
  localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;

  // Angle unit: 2^28 = 45 degrees, full turn = 2^31
  localparam logic [31:0] DEG45  = 32'h1000_0000;
  localparam logic [31:0] DEG90  = 32'h2000_0000;
  localparam logic [31:0] DEG180 = 32'h4000_0000;

  // 1/K in Q1.31
  localparam logic [31:0] KINV = 32'h4DBA_76D4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ROTATE = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  // round(atan(2^-i) * 2^30 / pi)
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_lut = 32'sh1000_0000;
      5'd1:  atan_lut = 32'sh0972_028F;
      5'd2:  atan_lut = 32'sh04FD_9C2E;
      5'd3:  atan_lut = 32'sh0288_88EA;
      5'd4:  atan_lut = 32'sh0145_86A2;
      5'd5:  atan_lut = 32'sh00A2_EBF1;
      5'd6:  atan_lut = 32'sh0051_7B0F;
      5'd7:  atan_lut = 32'sh0028_BE2B;
      5'd8:  atan_lut = 32'sh0014_5F2A;
      5'd9:  atan_lut = 32'sh000A_2F97;
      5'd10: atan_lut = 32'sh0005_17CC;
      5'd11: atan_lut = 32'sh0002_8BE6;
      5'd12: atan_lut = 32'sh0001_45F3;
      5'd13: atan_lut = 32'sh0000_A2FA;
      5'd14: atan_lut = 32'sh0000_517D;
      5'd15: atan_lut = 32'sh0000_28BE;
      5'd16: atan_lut = 32'sh0000_145F;
      5'd17: atan_lut = 32'sh0000_0A30;
      5'd18: atan_lut = 32'sh0000_0518;
      5'd19: atan_lut = 32'sh0000_028C;
      5'd20: atan_lut = 32'sh0000_0146;
      5'd21: atan_lut = 32'sh0000_00A3;
      5'd22: atan_lut = 32'sh0000_0051;
      5'd23: atan_lut = 32'sh0000_0029;
      5'd24: atan_lut = 32'sh0000_0014;
      5'd25: atan_lut = 32'sh0000_000A;
      5'd26: atan_lut = 32'sh0000_0005;
      5'd27: atan_lut = 32'sh0000_0003;
      5'd28: atan_lut = 32'sh0000_0001;
      5'd29: atan_lut = 32'sh0000_0001;
      default: atan_lut = 32'sh0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_rotator_iter_gain_scaler.sv
// Multiply by 1/K (Q1.31), arithmetic shift by 31, truncate to 32 bits.
// Only present when CORDIC_GAIN_COMP_EN is defined.
`ifdef CORDIC_GAIN_COMP_EN
module cordic_gain_scaler
  import cordic_pkg::*;
(
  input  logic signed [31:0] din,
  output logic signed [31:0] dout
);

  logic signed [63:0] din_ext;
  logic signed [63:0] kinv_ext;
  logic signed [63:0] prod;

  assign din_ext  = {{32{din[31]}}, din};
  assign kinv_ext = {32'd0, KINV};
  assign prod     = din_ext * kinv_ext;
  assign dout     = 32'(prod >>> 31);

endmodule
`endif

// File: rtl/cordic_rotator_iter.sv
// Iterative rotation-mode circular CORDIC sharing one add/shift stage.
// Optional gain compensation on the final result: CORDIC_GAIN_COMP_EN.
module cordic_rotator_iter
  import cordic_pkg::*;
#(
  parameter int NUM_ITER = 16,
  parameter int WIDTH    = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic        [WIDTH-1:0] angle_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] residual_angle
);

  localparam logic [4:0] LAST = 5'(NUM_ITER - 1);

  state_t state, state_nx;
  logic [4:0] iter;
  logic       accept;
  logic       last_step;

  logic signed [WIDTH-1:0] x_r, y_r, z_r;
  logic signed [WIDTH-1:0] x_init, y_init, z_init;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [WIDTH-1:0] x_sh, y_sh, x_fin, y_fin;

  logic [30:0] r;
  logic [31:0] r_bias;
  logic [1:0]  k;
  logic [30:0] z_diff;
  logic        unused_angle_msb;

  assign unused_angle_msb = angle_in[31];

  assign accept    = in_valid && (state == S_IDLE);
  assign last_step = (state == S_ROTATE) && (iter == LAST);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Quadrant folding: 31-bit wrap keeps the residual in [-45, +45) degrees
  assign r      = angle_in[30:0];
  assign r_bias = {1'b0, r} + DEG45;
  assign k      = r_bias[30:29];
  assign z_diff = r - {k, 29'd0};
  assign z_init = {z_diff[30], z_diff};

  always_comb begin
    x_init = x_in;
    y_init = y_in;
    case (k)
      2'd1: begin x_init = -y_in; y_init =  x_in; end
      2'd2: begin x_init = -x_in; y_init = -y_in; end
      2'd3: begin x_init =  y_in; y_init = -x_in; end
      default: ;
    endcase
  end

  assign x_sh = x_r >>> iter;
  assign y_sh = y_r >>> iter;

  always_comb begin
    if (!z_r[WIDTH-1]) begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - atan_lut(iter);
    end else begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + atan_lut(iter);
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  cordic_gain_scaler u_scale_x (.din(x_nx), .dout(x_fin));
  cordic_gain_scaler u_scale_y (.din(y_nx), .dout(y_fin));
`else
  assign x_fin = x_nx;
  assign y_fin = y_nx;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (in_valid)  state_nx = S_ROTATE;
      S_ROTATE: if (last_step) state_nx = S_DONE;
      S_DONE:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iter           <= '0;
      x_out          <= '0;
      y_out          <= '0;
      residual_angle <= '0;
    end else begin
      if (accept)                  iter <= '0;
      else if (state == S_ROTATE)  iter <= iter + 5'd1;
      if (last_step) begin
        x_out          <= x_fin;
        y_out          <= y_fin;
        residual_angle <= z_nx;
      end
    end
  end

  // Working registers carry no reset; they are always loaded on accept
  always_ff @(posedge clock) begin
    if (accept) begin
      x_r <= x_init;
      y_r <= y_init;
      z_r <= z_init;
    end else if (state == S_ROTATE) begin
      x_r <= x_nx;
      y_r <= y_nx;
      z_r <= z_nx;
    end
  end

endmodule
